pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//  Sequences the 5-stage ARM pipeline around the decode stage. Detects RAW hazards on the
//  decode stage's register-file sources (src1/src2) and drives its `hazard` input, which
//  nulls the decode control signals. Freezes the whole pipeline during multi-cycle data-memory
//  accesses and flushes IF/ID after a taken branch. Sits beside the pipeline registers and
//  collects inputs from the ID, EXE and MEM stages.
// PARAMETERS
//  REG_ADDR_W    4      register address width (`REG_ADDRESS_LEN)
//  FLUSH_CYCLES  1      cycles flush stays high per taken branch (>=1)
//  MEM_TIMEOUT   255    wait cycles before mem_timeout sets (>=1)
//  CNT_W         16     width of stall_cycles performance counter
// PORTS
//  clk            in   1           clock, rising edge
//  rst            in   1           synchronous reset, active-high
//  id_src1        in   REG_ADDR_W  decode first source (Instr[19:16])
//  id_src2        in   REG_ADDR_W  decode second source (muxed Rd/Rm)
//  id_two_src     in   1           decode instruction reads src2
//  exe_dest       in   REG_ADDR_W  EXE-stage destination register
//  exe_wb_en      in   1           EXE-stage writes back
//  exe_mem_read   in   1           EXE-stage instruction is a load
//  mem_dest       in   REG_ADDR_W  MEM-stage destination register
//  mem_wb_en      in   1           MEM-stage writes back
//  forward_en     in   1           forwarding unit active
//  mem_req        in   1           MEM-stage read or write enable
//  mem_ready      in   1           data memory has completed the access
//  branch_taken   in   1           EXE-stage branch resolved taken
//  cnt_clear      in   1           synchronous clear of stall_cycles
//  hazard         out  1           to decode stage: null control signals
//  freeze_if      out  1           hold PC and IF/ID register
//  freeze_pipe    out  1           hold all pipeline registers
//  flush          out  1           clear IF/ID (and ID/EXE) contents
//  mem_timeout    out  1           sticky memory-timeout error
//  stall_cycles   out  CNT_W       count of stalled cycles
// BEHAVIOUR
//  - Reset: state=RUN, wait_cnt=0, flush_cnt=0, mem_timeout=0, stall_cycles=0. Combinational
//    outputs take the RUN values that follow from the current inputs.
//  - raw_exe = exe_wb_en & (id_src1==exe_dest | id_two_src & id_src2==exe_dest);
//    raw_mem is defined the same way using mem_wb_en/mem_dest.
//  - raw = forward_en ? (raw_exe & exe_mem_read) : (raw_exe | raw_mem).
//  - freeze_pipe = mem_req & ~mem_ready (combinational, any state). It has highest priority.
//  - flush = ~freeze_pipe & (branch_taken | state==FLUSH).
//  - hazard = freeze_if = ~freeze_pipe & ~flush & raw.
//    During freeze, decode is held anyway; hazard is forced to 0.
//  - FSM states are RUN, MEM_WAIT and FLUSH:
//    RUN->MEM_WAIT when freeze_pipe. MEM_WAIT->RUN on the cycle after mem_ready=1.
//    RUN->FLUSH when flush & FLUSH_CYCLES>1. flush_cnt loads FLUSH_CYCLES-1.
//    FLUSH decrements flush_cnt and returns to RUN at 0. A new branch_taken in FLUSH reloads flush_cnt.
//    A freeze in FLUSH moves to MEM_WAIT, and the remaining flush is dropped.
//  - wait_cnt increments each MEM_WAIT cycle and saturates; it clears on leaving MEM_WAIT.
//    mem_timeout sets when wait_cnt==MEM_TIMEOUT and stays set until rst. The freeze continues.
//  - A branch_taken while frozen is not lost. EXE is held, so flush fires on the first
//    unfrozen cycle.
//  - stall_cycles += 1 on cycles with freeze_pipe|hazard, saturating at all-ones.
//    cnt_clear has priority over increment.
//  - Reset in mid-operation (MEM_WAIT/FLUSH) takes effect next edge and applies all reset values.
//  - Zero-cycle latency from inputs to hazard/freeze/flush. The FSM adds state only.
// TESTING
//  1 fwd=0, exe_wb_en=1, exe_dest=3, id_src1=3 -> hazard=freeze_if=1; exe_wb_en=0,
//    mem_wb_en=1, mem_dest=3 -> hazard=1; dest=4 -> 0.
//  2 fwd=1, same EXE match, exe_mem_read=0 -> hazard=0; exe_mem_read=1 -> hazard=1.
//    id_two_src=0 with src2 match only -> 0.
//  3 mem_req=1, mem_ready=0 for 5 cycles, then 1 -> freeze_pipe=1 for exactly 5 cycles,
//    hazard=0 throughout, stall_cycles=5, then RUN.
//  4 FLUSH_CYCLES=2, branch_taken 1 cycle -> flush=1 for 2 cycles. An EXE-match hazard
//    during those cycles stays masked.
//  5 MEM_TIMEOUT=4, mem_ready=0 for 10 cycles -> mem_timeout rises after the 4th wait cycle
//    and stays 1 after mem_ready. rst mid-wait -> all outputs reset next edge.
//  6 branch_taken=1 during freeze -> flush=0 until mem_ready=1, then flush=1.
//    stall_cycles at all-ones stays saturated; cnt_clear -> 0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard, freeze and flush sequencing for the 5-stage pipeline around the decode stage.
// RAW detection and freeze/flush outputs are combinational; the FSM only adds flush and wait state.
module pipeline_hazard_controller #(
    parameter int REG_ADDR_W   = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  forward_en,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    input  logic                  branch_taken,
    input  logic                  cnt_clear,
    output logic                  hazard,
    output logic                  freeze_if,
    output logic                  freeze_pipe,
    output logic                  flush,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [FLUSH_W-1:0] flush_cnt, flush_cnt_next;
    logic [WAIT_W-1:0]  wait_cnt, wait_cnt_next;
    logic               raw_exe, raw_mem, raw;

    assign raw_exe = exe_wb_en & ((id_src1 == exe_dest) | (id_two_src & (id_src2 == exe_dest)));
    assign raw_mem = mem_wb_en & ((id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest)));
    // With forwarding only a load in EXE cannot be bypassed in time.
    assign raw     = forward_en ? (raw_exe & exe_mem_read) : (raw_exe | raw_mem);

    assign freeze_pipe = mem_req & ~mem_ready;
    assign flush       = ~freeze_pipe & (branch_taken | (state == FLUSH));
    assign hazard      = ~freeze_pipe & ~flush & raw;
    assign freeze_if   = hazard;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next     = state;
        flush_cnt_next = flush_cnt;
        wait_cnt_next  = '0;
        if (freeze_pipe) begin
            // A freeze drops any remaining flush; the held EXE branch re-fires afterwards.
            state_next     = MEM_WAIT;
            flush_cnt_next = '0;
            wait_cnt_next  = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
        end else if (branch_taken && (FLUSH_CYCLES > 1)) begin
            state_next     = FLUSH;
            flush_cnt_next = FLUSH_LOAD;
        end else if ((state == FLUSH) && (flush_cnt > FLUSH_W'(1))) begin
            flush_cnt_next = flush_cnt - 1'b1;
        end else begin
            state_next     = RUN;
            flush_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state        <= RUN;
            flush_cnt    <= '0;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            wait_cnt  <= wait_cnt_next;
            if (freeze_pipe && (wait_cnt_next == WAIT_MAX)) begin
                mem_timeout <= 1'b1;
            end
            if (cnt_clear) begin
                stall_cycles <= '0;
            end else if ((freeze_pipe | hazard) && !(&stall_cycles)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed and randomized checks of pipeline_hazard_controller against a cycle-level
// reference model expressed as pending-flush count, frozen-run length and a stall counter.
module tb_pipeline_hazard_controller;

    localparam int FC      = 2;
    localparam int MT      = 4;
    localparam int CW      = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic [3:0]    id_src1, id_src2, exe_dest, mem_dest;
    logic          id_two_src, exe_wb_en, exe_mem_read, mem_wb_en, forward_en;
    logic          mem_req, mem_ready, branch_taken, cnt_clear;
    logic          hazard, freeze_if, freeze_pipe, flush, mem_timeout;
    logic [CW-1:0] stall_cycles;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int m_flush_left = 0;
    int m_frozen_run = 0;
    bit m_timeout    = 1'b0;
    int m_stall      = 0;

    pipeline_hazard_controller #(
        .REG_ADDR_W  (4),
        .FLUSH_CYCLES(FC),
        .MEM_TIMEOUT (MT),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_two_src  (id_two_src),
        .exe_dest    (exe_dest),
        .exe_wb_en   (exe_wb_en),
        .exe_mem_read(exe_mem_read),
        .mem_dest    (mem_dest),
        .mem_wb_en   (mem_wb_en),
        .forward_en  (forward_en),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .branch_taken(branch_taken),
        .cnt_clear   (cnt_clear),
        .hazard      (hazard),
        .freeze_if   (freeze_if),
        .freeze_pipe (freeze_pipe),
        .flush       (flush),
        .mem_timeout (mem_timeout),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic idle();
        rst = 1'b0; id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
        exe_dest = 4'd15; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
        mem_dest = 4'd15; mem_wb_en = 1'b0; forward_en = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; cnt_clear = 1'b0;
    endtask

    // Expected combinational outputs from the current inputs and model state.
    task automatic model_comb(output bit frz, output bit fl, output bit hz);
        bit hit_exe, hit_mem, dep;
        hit_exe = exe_wb_en && (id_src1 == exe_dest || (id_two_src && id_src2 == exe_dest));
        hit_mem = mem_wb_en && (id_src1 == mem_dest || (id_two_src && id_src2 == mem_dest));
        dep     = forward_en ? (hit_exe && exe_mem_read) : (hit_exe || hit_mem);
        frz     = mem_req && !mem_ready;
        fl      = !frz && (branch_taken || m_flush_left > 0);
        hz      = !frz && !fl && dep;
    endtask

    // One clock: compare everything mid-cycle, then advance the model on the edge.
    task automatic tick();
        bit frz, fl, hz;
        @(negedge clk);
        model_comb(frz, fl, hz);
        check("hazard",       32'(hazard),       32'(hz));
        check("freeze_if",    32'(freeze_if),    32'(hz));
        check("freeze_pipe",  32'(freeze_pipe),  32'(frz));
        check("flush",        32'(flush),        32'(fl));
        check("mem_timeout",  32'(mem_timeout),  32'(m_timeout));
        check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        @(posedge clk);
        if (rst) begin
            m_flush_left = 0; m_frozen_run = 0; m_timeout = 1'b0; m_stall = 0;
        end else begin
            if (frz) begin
                m_frozen_run = (m_frozen_run < MT) ? m_frozen_run + 1 : MT;
                if (m_frozen_run >= MT) m_timeout = 1'b1;
                m_flush_left = 0;
            end else begin
                m_frozen_run = 0;
                if (branch_taken)          m_flush_left = FC - 1;
                else if (m_flush_left > 0) m_flush_left--;
            end
            if (cnt_clear)                        m_stall = 0;
            else if ((frz || hz) && m_stall < CNT_MAX) m_stall++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        #1;
        check("reset_stall", 32'(stall_cycles), 32'd0);
        check("reset_timeout", 32'(mem_timeout), 32'd0);
        check("reset_flush", 32'(flush), 32'd0);

        // 1: no forwarding, EXE and MEM matches
        exe_wb_en = 1'b1; exe_dest = 4'd3; id_src1 = 4'd3; #1;
        check("t1_exe_hazard", 32'(hazard), 32'd1);
        check("t1_exe_freeze_if", 32'(freeze_if), 32'd1);
        tick();
        exe_wb_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd3; #1;
        check("t1_mem_hazard", 32'(hazard), 32'd1);
        tick();
        mem_dest = 4'd4; #1;
        check("t1_no_match", 32'(hazard), 32'd0);
        tick();

        // 2: forwarding, only loads in EXE stall; src2 ignored without id_two_src
        idle(); forward_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3; id_src1 = 4'd3; #1;
        check("t2_fwd_alu", 32'(hazard), 32'd0);
        tick();
        exe_mem_read = 1'b1; #1;
        check("t2_fwd_load", 32'(hazard), 32'd1);
        tick();
        id_src1 = 4'd5; id_src2 = 4'd3; id_two_src = 1'b0; #1;
        check("t2_src2_unused", 32'(hazard), 32'd0);
        tick();
        id_two_src = 1'b1; #1;
        check("t2_src2_used", 32'(hazard), 32'd1);
        tick();

        // 3: five-cycle memory freeze masks a pending hazard
        idle(); cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0; mem_req = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd7; id_src1 = 4'd7;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_freeze", 32'(freeze_pipe), 32'd1);
            check("t3_hazard_masked", 32'(hazard), 32'd0);
            tick();
        end
        mem_ready = 1'b1; exe_wb_en = 1'b0; #1;
        check("t3_unfrozen", 32'(freeze_pipe), 32'd0);
        check("t3_stall_count", 32'(stall_cycles), 32'd5);
        tick();
        idle();
        tick();

        // 4: two-cycle flush masks an EXE hazard
        do_reset();
        exe_wb_en = 1'b1; exe_dest = 4'd2; id_src1 = 4'd2; branch_taken = 1'b1; #1;
        check("t4_flush0", 32'(flush), 32'd1);
        check("t4_mask0", 32'(hazard), 32'd0);
        tick();
        branch_taken = 1'b0; #1;
        check("t4_flush1", 32'(flush), 32'd1);
        check("t4_mask1", 32'(hazard), 32'd0);
        tick();
        #1;
        check("t4_flush_done", 32'(flush), 32'd0);
        check("t4_hazard_back", 32'(hazard), 32'd1);
        tick();

        // 5: timeout after the fourth wait cycle, sticky until reset
        idle(); do_reset();
        mem_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            #1;
            check("t5_timeout", 32'(mem_timeout), (i > MT) ? 32'd1 : 32'd0);
            tick();
        end
        mem_ready = 1'b1; #1;
        check("t5_sticky", 32'(mem_timeout), 32'd1);
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        check("t5_rst_timeout", 32'(mem_timeout), 32'd0);
        check("t5_rst_stall", 32'(stall_cycles), 32'd0);
        idle();
        tick();

        // 6: branch held across a freeze, then counter saturation and clear
        mem_req = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t6_flush_held", 32'(flush), 32'd0);
            tick();
        end
        mem_ready = 1'b1; #1;
        check("t6_flush_fires", 32'(flush), 32'd1);
        tick();
        idle(); #1;
        check("t6_flush_second", 32'(flush), 32'd1);
        tick();
        mem_req = 1'b1;
        for (int i = 0; i < 70; i++) tick();
        #1;
        check("t6_saturated", 32'(stall_cycles), 32'(CNT_MAX));
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0; #1;
        check("t6_cleared", 32'(stall_cycles), 32'd0);
        idle(); do_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 59) == 0);
            id_src1      = 4'($urandom_range(0, 3));
            id_src2      = 4'($urandom_range(0, 3));
            id_two_src   = 1'($urandom_range(0, 1));
            exe_dest     = 4'($urandom_range(0, 3));
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_mem_read = 1'($urandom_range(0, 1));
            mem_dest     = 4'($urandom_range(0, 3));
            mem_wb_en    = 1'($urandom_range(0, 1));
            forward_en   = 1'($urandom_range(0, 1));
            mem_req      = ($urandom_range(0, 2) == 0);
            mem_ready    = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            cnt_clear    = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
